// File: rtl/cnt_pkg.sv
// Shared types for the loadable down-counter: FSM state encoding and the
// per-edge action selected by the control logic for the datapath core.
package cnt_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_e;

  // Exactly one of these is applied to the count register on each edge.
  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_LOAD   = 3'd2,
    OP_DEC    = 3'd3,
    OP_RELOAD = 3'd4
  } cnt_op_e;

  function automatic logic [STATE_W-1:0] state_code(input cnt_state_e s);
    return STATE_W'(s);
  endfunction

endpackage

// File: rtl/cnt_down_core.sv
// Datapath of the down-counter: count register, decrementer, reload register
// and zero / one detection. The action is chosen by the enclosing control FSM.
module cnt_down_core
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             q_zero,
  output logic             q_one
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;

  always_comb begin
    q_next      = q_reg;
    reload_next = reload_reg;
    case (op)
      OP_CLEAR:  q_next = '0;
      OP_LOAD: begin
        q_next      = load_val;
        reload_next = load_val;
      end
      OP_DEC:    q_next = q_reg - WIDTH'(1);
      OP_RELOAD: q_next = reload_reg;
      default:   ;
    endcase
  end

  // A clear leaves the reload register untouched; only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg      <= '0;
      reload_reg <= '0;
    end else begin
      q_reg      <= q_next;
      reload_reg <= reload_next;
    end
  end

  assign q      = q_reg;
  assign q_zero = (q_reg == '0);
  assign q_one  = (q_reg == WIDTH'(1));

endmodule

// File: rtl/cnt_down_loadable.sv
// Loadable, cascadable down-counter with terminal-count pulse and optional
// auto-reload. Control FSM and action priority here; datapath in cnt_down_core.
module cnt_down_loadable
  import cnt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               enp,
  input  logic               ent,
  output logic [WIDTH-1:0]   q,
  output logic               bo,
  output logic               tc_pulse,
  output logic [STATE_W-1:0] state
);

  cnt_state_e state_reg;
  cnt_state_e state_next;
  logic       tc_reg;
  logic       tc_next;
  cnt_op_e    op;
  logic       q_zero;
  logic       q_one;
  logic       count_en;

  cnt_down_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .load_val (load_val),
    .q        (q),
    .q_zero   (q_zero),
    .q_one    (q_one)
  );

  assign count_en = (state_reg == ST_RUN) && enp && ent;

  // Priority: clear, then load, then count.
  always_comb begin
    state_next = state_reg;
    tc_next    = 1'b0;
    op         = OP_HOLD;
    if (!clr_n) begin
      op         = OP_CLEAR;
      state_next = ST_IDLE;
    end else if (load) begin
      op         = OP_LOAD;
      state_next = (load_val != '0) ? ST_RUN : ST_DONE;
    end else if (count_en) begin
      if (q_zero) begin
        // Only reachable with auto-reload, since RUN is left on 1->0 otherwise.
        if (AUTO_RELOAD) begin
          op = OP_RELOAD;
        end else begin
          state_next = ST_DONE;
        end
      end else begin
        op = OP_DEC;
        if (q_one) begin
          tc_next = 1'b1;
          if (!AUTO_RELOAD) begin
            state_next = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tc_reg    <= tc_next;
    end
  end

  assign tc_pulse = tc_reg;
  assign state    = state_code(state_reg);
  assign bo       = ent & q_zero;

endmodule

// File: tb/tb_cnt_down_loadable.sv
// Randomised and directed bench for cnt_down_loadable: a stop-at-zero and an
// auto-reload instance share stimulus and are compared to a behavioural model.
module tb_cnt_down_loadable;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clr_n, load, enp, ent;
  logic [W-1:0] load_val;
  logic [W-1:0] q0, q1;
  logic         bo0, bo1, tc0, tc1;
  logic [1:0]   st0, st1;

  logic         c_load_lo, c_load_hi, c_en_lo;
  logic [W-1:0] c_lv_lo, c_lv_hi;
  logic [W-1:0] cl_q, ch_q;
  logic         cl_bo, ch_bo, cl_tc, ch_tc;
  logic [1:0]   cl_st, ch_st;

  cnt_down_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_ar0 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load(load), .load_val(load_val),
    .enp(enp), .ent(ent), .q(q0), .bo(bo0), .tc_pulse(tc0), .state(st0));

  cnt_down_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_ar1 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load(load), .load_val(load_val),
    .enp(enp), .ent(ent), .q(q1), .bo(bo1), .tc_pulse(tc1), .state(st1));

  // Two-slice cascade: low slice wraps via reload of 15, high slice trickles on bo.
  cnt_down_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load(c_load_lo), .load_val(c_lv_lo),
    .enp(c_en_lo), .ent(c_en_lo), .q(cl_q), .bo(cl_bo), .tc_pulse(cl_tc), .state(cl_st));

  cnt_down_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load(c_load_hi), .load_val(c_lv_hi),
    .enp(1'b1), .ent(cl_bo), .q(ch_q), .bo(ch_bo), .tc_pulse(ch_tc), .state(ch_st));

  typedef struct {
    int q;
    int st;   // 0 idle, 1 run, 2 done
    int tc;
    int rl;
  } mdl_t;

  mdl_t m0, m1;
  int   errors = 0;
  int   checks = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.q = 0; r.st = 0; r.tc = 0; r.rl = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit ar, bit c_n, bit ld, int lv,
                                    bit ep, bit et);
    mdl_t n;
    n = m;
    n.tc = 0;
    if (!c_n) begin
      n.q = 0; n.st = 0;
    end else if (ld) begin
      n.q = lv; n.rl = lv; n.st = (lv == 0) ? 2 : 1;
    end else if (m.st == 1 && ep && et) begin
      if (m.q == 0) begin
        n.q = m.rl;
      end else begin
        n.q = m.q - 1;
        if (n.q == 0) begin
          n.tc = 1;
          if (!ar) n.st = 2;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_models();
    check("ar0_q",  32'(q0),  32'(m0.q));
    check("ar0_st", 32'(st0), 32'(m0.st));
    check("ar0_tc", 32'(tc0), 32'(m0.tc));
    check("ar0_bo", 32'(bo0), 32'(ent && m0.q == 0));
    check("ar1_q",  32'(q1),  32'(m1.q));
    check("ar1_st", 32'(st1), 32'(m1.st));
    check("ar1_tc", 32'(tc1), 32'(m1.tc));
    check("ar1_bo", 32'(bo1), 32'(ent && m1.q == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m0 = mdl_next(m0, 1'b0, clr_n, load, int'(load_val), enp, ent);
      m1 = mdl_next(m1, 1'b1, clr_n, load, int'(load_val), enp, ent);
    end else begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end
    #1;
    $display("t=%0t clr_n=%0b load=%0b lv=%0d enp=%0b ent=%0b | q0=%0d st0=%0d tc0=%0b | q1=%0d st1=%0d tc1=%0b",
             $time, clr_n, load, load_val, enp, ent, q0, st0, tc0, q1, st1, tc1);
    check_models();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int exp_b[8];
    int ntc;
    exp_b = '{3, 2, 1, 0, 3, 2, 1, 0};

    rst_n = 1'b0; clr_n = 1'b1; load = 1'b0; load_val = '0; enp = 1'b0; ent = 1'b0;
    c_load_lo = 1'b0; c_load_hi = 1'b0; c_en_lo = 1'b0; c_lv_lo = '0; c_lv_hi = '0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    repeat (2) tick();
    check("reset_q", 32'(q0), 0);
    check("reset_st", 32'(st0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stop-at-zero sequence from 5, then hold in DONE.
    load = 1'b1; load_val = 4'd5; enp = 1'b1; ent = 1'b1;
    tick();
    load = 1'b0;
    check("ar0_load5", 32'(q0), 5);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("ar0_seq", 32'(q0), 32'(i));
      check("ar0_tc_at0", 32'(tc0), 32'(i == 0));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ar0_done_st", 32'(st0), 2);
      check("ar0_done_q", 32'(q0), 0);
    end

    // Auto-reload period of 4 from a load of 3.
    load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("ar1_seq", 32'(q1), 32'(exp_b[i]));
      check("ar1_tc", 32'(tc1), 32'(exp_b[i] == 0));
      check("ar1_run", 32'(st1), 1);
    end

    // Enable gating and borrow gating.
    load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("gate_at4", 32'(q0), 4);
    enp = 1'b0;
    repeat (2) begin
      tick();
      check("gate_hold", 32'(q0), 4);
    end
    enp = 1'b1;
    repeat (4) tick();
    check("gate_zero", 32'(q0), 0);
    ent = 1'b0;
    #1 check("bo_ent0", 32'(bo0), 0);
    ent = 1'b1;
    #1 check("bo_ent1", 32'(bo0), 1);

    // Priority: clear over load, load over terminal decrement.
    clr_n = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    check("clr_over_load_q", 32'(q0), 0);
    check("clr_over_load_st", 32'(st0), 0);
    clr_n = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("pre_prio_q1", 32'(q0), 1);
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    check("load_over_tc_q", 32'(q0), 9);
    check("load_over_tc_tc", 32'(tc0), 0);

    // Load of zero goes straight to DONE without a pulse.
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    check("load0_st", 32'(st0), 2);
    repeat (5) begin
      tick();
      check("load0_no_tc", 32'(tc0), 0);
    end

    // Full-scale load: 15 enabled cycles, one pulse.
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    ntc = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      ntc += int'(tc0);
    end
    check("load15_q", 32'(q0), 0);
    check("load15_tc_count", 32'(ntc), 1);

    // Asynchronous reset asserted between edges while running at 9.
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("pre_rst_q", 32'(q0), 9);
    #2;
    rst_n = 1'b0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    #1;
    check("async_rst_q", 32'(q0), 0);
    check("async_rst_st", 32'(st0), 0);
    check("async_rst_tc", 32'(tc0), 0);
    load = 1'b1; load_val = 4'd5;
    repeat (2) tick();
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clr_n    = ($urandom_range(0, 19) != 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom);
      enp      = ($urandom_range(0, 4) != 0);
      ent      = ($urandom_range(0, 4) != 0);
      tick();
    end

    // Cascade: preset low slice reload to 15, stop it at 2, load high with 1.
    clr_n = 1'b1; load = 1'b0; enp = 1'b0; ent = 1'b0;
    c_load_lo = 1'b1; c_lv_lo = 4'd15;
    tick();
    c_load_lo = 1'b0; c_en_lo = 1'b1;
    for (int v = 14; v >= 2; v--) begin
      tick();
      check("casc_lo_pre", 32'(cl_q), 32'(v));
    end
    c_en_lo = 1'b0; c_load_hi = 1'b1; c_lv_hi = 4'd1;
    tick();
    c_load_hi = 1'b0;
    check("casc_start", 32'({ch_q, cl_q}), 32'h12);
    c_en_lo = 1'b1;
    ntc = 0;
    for (int v = 32'h11; v >= 0; v--) begin
      tick();
      check("casc_val", 32'({ch_q, cl_q}), 32'(v));
      ntc += int'(ch_tc);
    end
    check("casc_hi_tc_count", 32'(ntc), 1);
    check("casc_hi_done", 32'(ch_st), 2);
    c_en_lo = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
